// File: rtl/sid_pkg.sv
// Shared constants and types for the SID voice sequencer.
// Register offsets are relative to a voice base of 7*v.
package sid_pkg;

   localparam int ACC_W      = 24;
   localparam int FREQ_W     = 16;
   localparam int PW_W       = 12;
   localparam int DEF_VOICES = 3;

   localparam int REG_FREQ_LO = 0;
   localparam int REG_FREQ_HI = 1;
   localparam int REG_PW_LO   = 2;
   localparam int REG_PW_HI   = 3;
   localparam int REG_CTRL    = 4;

   localparam int CTRL_SYNC_BIT = 1;
   localparam int CTRL_TEST_BIT = 3;

   localparam logic [4:0] CLR_OVR_ADDR = 5'd31;

   typedef enum logic {
      IDLE,
      RUN
   } seq_state_t;

   typedef struct packed {
      logic [FREQ_W-1:0] freq;
      logic [PW_W-1:0]   pw;
      logic [7:0]        ctrl;
   } voice_regs_t;

endpackage

// File: rtl/sid_voice_regfile.sv
// Per-voice CPU-visible staging registers and the pass snapshot.
// A write coinciding with an accepted tick lands in the snapshot too.
module sid_voice_regfile
   import sid_pkg::*;
#(
   parameter int NUM_VOICES = DEF_VOICES
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         we_i,
   input  logic [4:0]                   addr_i,
   input  logic [7:0]                   wdata_i,
   input  logic                         accept_i,
   output voice_regs_t [NUM_VOICES-1:0] snap_o,
   output logic                         clr_ovr_o
);

   voice_regs_t [NUM_VOICES-1:0] stage_q, stage_d, snap_q;

   always_comb begin
      stage_d = stage_q;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (we_i && addr_i == 5'(7 * v + REG_FREQ_LO))
            stage_d[v].freq[7:0] = wdata_i;
         if (we_i && addr_i == 5'(7 * v + REG_FREQ_HI))
            stage_d[v].freq[FREQ_W-1:8] = wdata_i;
         if (we_i && addr_i == 5'(7 * v + REG_PW_LO))
            stage_d[v].pw[7:0] = wdata_i;
         if (we_i && addr_i == 5'(7 * v + REG_PW_HI))
            stage_d[v].pw[PW_W-1:8] = wdata_i[PW_W-9:0];
         if (we_i && addr_i == 5'(7 * v + REG_CTRL))
            stage_d[v].ctrl = wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= '0;
         snap_q  <= '0;
      end else begin
         stage_q <= stage_d;
         // Snapshot the post-write view so a same-cycle write is merged.
         if (accept_i)
            snap_q <= stage_d;
      end
   end

   assign snap_o    = snap_q;
   assign clr_ovr_o = we_i & (addr_i == CLR_OVR_ADDR);

endmodule

// File: rtl/sid_voice_sequencer.sv
// Time-multiplexed phase accumulator sequencer for the SID voices.
// One shared adder walks the voices slot by slot on each accepted tick.
module sid_voice_sequencer
   import sid_pkg::*;
#(
   parameter int NUM_VOICES = DEF_VOICES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             reg_wr,
   input  logic [4:0]       reg_addr,
   input  logic [7:0]       reg_wdata,
   output logic [1:0]       voice_idx,
   output logic [ACC_W-1:0] acc_out,
   output logic             acc_valid,
   output logic             pulse_out,
   output logic             msb_rise,
   output logic             overrun,
   output logic             busy
);

   localparam logic [1:0] LAST = 2'(NUM_VOICES - 1);

   voice_regs_t [NUM_VOICES-1:0] snap;
   voice_regs_t                  cur;

   seq_state_t state_q, state_d;
   logic [1:0] slot_q, slot_d, src;
   logic       ovr_q, ovr_d;
   logic       accept, drop, clr_ovr;

   logic [NUM_VOICES-1:0][ACC_W-1:0] acc_q;
   logic [NUM_VOICES-1:0]            rise_q, rise_snap_q;

   logic [ACC_W-1:0] acc_old, acc_new;
   logic             test, sync, rise_new, pulse_new;

   logic [1:0]       vidx_q;
   logic [ACC_W-1:0] acc_out_q;
   logic             valid_q, pulse_q, rise_out_q, busy_q;

   assign accept = tick & (state_q == IDLE);
   assign drop   = tick & (state_q == RUN);

   sid_voice_regfile #(
      .NUM_VOICES(NUM_VOICES)
   ) u_regs (
      .clk      (clk),
      .rst_n    (rst),
      .we_i     (reg_wr),
      .addr_i   (reg_addr),
      .wdata_i  (reg_wdata),
      .accept_i (accept),
      .snap_o   (snap),
      .clr_ovr_o(clr_ovr)
   );

   always_comb begin
      cur      = snap[slot_q];
      src      = (slot_q == 2'd0) ? LAST : slot_q - 2'd1;
      acc_old  = acc_q[slot_q];
      test     = cur.ctrl[CTRL_TEST_BIT];
      // Sync looks at the source flag frozen at pass start.
      sync     = cur.ctrl[CTRL_SYNC_BIT] & rise_snap_q[src];
      acc_new  = acc_old + ACC_W'(cur.freq);
      if (test | sync)
         acc_new = '0;
      rise_new  = ~acc_old[ACC_W-1] & acc_new[ACC_W-1];
      pulse_new = (acc_new[ACC_W-1 -: PW_W] >= cur.pw) | test;
   end

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      ovr_d   = ovr_q;
      unique case (state_q)
         IDLE: begin
            if (tick) begin
               state_d = RUN;
               slot_d  = 2'd0;
            end
         end
         RUN: begin
            if (slot_q == LAST) begin
               state_d = IDLE;
               slot_d  = 2'd0;
            end else begin
               slot_d = slot_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (drop)
         ovr_d = 1'b1;
      else if (clr_ovr)
         ovr_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         ovr_q       <= 1'b0;
         acc_q       <= '0;
         rise_q      <= '0;
         rise_snap_q <= '0;
         vidx_q      <= '0;
         acc_out_q   <= '0;
         valid_q     <= 1'b0;
         pulse_q     <= 1'b0;
         rise_out_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         ovr_q   <= ovr_d;
         busy_q  <= (state_q == RUN);
         valid_q <= (state_q == RUN);
         if (accept)
            rise_snap_q <= rise_q;
         if (state_q == RUN) begin
            acc_q[slot_q]  <= acc_new;
            rise_q[slot_q] <= rise_new;
            vidx_q         <= slot_q;
            acc_out_q      <= acc_new;
            pulse_q        <= pulse_new;
            rise_out_q     <= rise_new;
         end else begin
            pulse_q    <= 1'b0;
            rise_out_q <= 1'b0;
         end
      end
   end

   assign voice_idx = vidx_q;
   assign acc_out   = acc_out_q;
   assign acc_valid = valid_q;
   assign pulse_out = pulse_q;
   assign msb_rise  = rise_out_q;
   assign overrun   = ovr_q;
   assign busy      = busy_q;

endmodule
